addsub_rr_arbiter: RTL and testbench



---
 rtl/addsub_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_addsub_rr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one combinational W-bit
//             adder/subtractor between NREQ requesters. The winning
//             requester's operands drive the shared unit and its result is
//             captured into a single registered response slot tagged with
//             the requester index.
//  Ports    : clk, rst                 clock, asynchronous active-high reset
//             req_valid_i/req_ready_o  per-requester handshake (ready one-hot)
//             req_a_i/req_b_i          packed operands, slice i*W +: W
//             req_mode_i               per-requester op (0 add, 1 subtract)
//             add_a_o/add_b_o/add_mode_o  drive to the shared adder
//             add_sum_i/add_cout_i/add_ovf_i  result from the shared adder
//             rsp_valid_o/rsp_ready_i  response slot handshake
//             rsp_id_o/rsp_sum_o/rsp_cout_o/rsp_ovf_o  registered response
//  Revision : 1.0  initial release
// ============================================================================
module addsub_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    input  logic [NREQ-1:0]   req_mode_i,
    output logic [W-1:0]      add_a_o,
    output logic [W-1:0]      add_b_o,
    output logic              add_mode_o,
    input  logic [W-1:0]      add_sum_i,
    input  logic              add_cout_i,
    input  logic              add_ovf_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [W-1:0]      rsp_sum_o,
    output logic              rsp_cout_o,
    output logic              rsp_ovf_o
);

    // Response slot occupancy
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]     state_q;
    logic [0:0]     state_d;
    logic [IDW-1:0] last_grant_q;

    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_sum_q;
    logic           rsp_cout_q;
    logic           rsp_ovf_q;

    // Last granted operands, replayed to the adder while idle so its inputs
    // stay quiet when nobody is being served.
    logic [W-1:0]   hold_a_q;
    logic [W-1:0]   hold_b_q;
    logic           hold_mode_q;

    logic           w_found;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_accept_ok;
    logic           w_grant;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic           w_sel_mode;

    // (base + step) mod NREQ for step in 1..NREQ; base is always < NREQ,
    // so a single conditional subtract is enough.
    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base,
                                              input int             step);
        int s;
        s = int'(base) + step;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin search starting just after the previous winner; the
    // previous winner itself is visited last (step == NREQ).
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid_i[f_wrap(last_grant_q, k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = f_wrap(last_grant_q, k);
            end
        end
    end

    assign w_sel_a    = req_a_i[w_gnt_idx*W +: W];
    assign w_sel_b    = req_b_i[w_gnt_idx*W +: W];
    assign w_sel_mode = req_mode_i[w_gnt_idx];

    // A FULL slot can be refilled in the same cycle it is drained.
    assign w_accept_ok = (state_q == c_EMPTY) || rsp_ready_i;
    assign w_grant     = w_accept_ok && w_found;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_EMPTY: begin
                if (w_grant) begin
                    state_d = c_FULL;
                end
            end
            c_FULL: begin
                if (!w_grant && rsp_ready_i) begin
                    state_d = c_EMPTY;
                end
            end
            default: state_d = c_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
        add_a_o     = w_grant ? w_sel_a    : hold_a_q;
        add_b_o     = w_grant ? w_sel_b    : hold_b_q;
        add_mode_o  = w_grant ? w_sel_mode : hold_mode_q;
        rsp_valid_o = (state_q == c_FULL);
    end

    // ------------------------------------------------------------------
    // Response capture and arbitration history; only real grants move it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= IDW'(NREQ - 1);
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            hold_mode_q  <= 1'b0;
        end else if (w_grant) begin
            last_grant_q <= w_gnt_idx;
            rsp_id_q     <= w_gnt_idx;
            rsp_sum_q    <= add_sum_i;
            rsp_cout_q   <= add_cout_i;
            rsp_ovf_q    <= add_ovf_i;
            hold_a_q     <= w_sel_a;
            hold_b_q     <= w_sel_b;
            hold_mode_q  <= w_sel_mode;
        end
    end

    assign rsp_id_o   = rsp_id_q;
    assign rsp_sum_o  = rsp_sum_q;
    assign rsp_cout_o = rsp_cout_q;
    assign rsp_ovf_o  = rsp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_rr_arbiter
//  Purpose  : Self-checking bench for addsub_rr_arbiter with a behavioural
//             model of arbitration and arithmetic, directed vectors and a
//             random phase. Provides the shared adder as environment.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_mode;
    logic [W-1:0]      add_a, add_b, add_sum;
    logic              add_mode, add_cout, add_ovf;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout, rsp_ovf;

    always #5 clk = ~clk;

    // Shared adder/subtractor: a + (b ^ {W{mode}}) + mode
    logic [W-1:0] w_bx;
    logic [W:0]   w_full;
    assign w_bx     = add_b ^ {W{add_mode}};
    assign w_full   = {1'b0, add_a} + {1'b0, w_bx} + {{W{1'b0}}, add_mode};
    assign add_sum  = w_full[W-1:0];
    assign add_cout = w_full[W];
    assign add_ovf  = (add_a[W-1] == w_bx[W-1]) && (add_sum[W-1] != add_a[W-1]);

    addsub_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_a_i    (req_a),
        .req_b_i    (req_b),
        .req_mode_i (req_mode),
        .add_a_o    (add_a),
        .add_b_o    (add_b),
        .add_mode_o (add_mode),
        .add_sum_i  (add_sum),
        .add_cout_i (add_cout),
        .add_ovf_i  (add_ovf),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_id_o   (rsp_id),
        .rsp_sum_o  (rsp_sum),
        .rsp_cout_o (rsp_cout),
        .rsp_ovf_o  (rsp_ovf)
    );

    // Stimulus state per requester, packed onto the DUT buses
    logic [W-1:0] ta [NREQ];
    logic [W-1:0] tb [NREQ];
    logic         tm [NREQ];
    logic         tv [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = tv[i];
            req_mode[i]        = tm[i];
            req_a[i*W +: W]    = ta[i];
            req_b[i*W +: W]    = tb[i];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_valid = 1'b0;
    int              m_id = 0;
    logic [W-1:0]    m_sum = '0;
    bit              m_cout = 1'b0, m_ovf = 1'b0;
    int              m_last = NREQ - 1;
    logic [W-1:0]    m_ha = '0, m_hb = '0;
    bit              m_hm = 1'b0;
    logic [NREQ-1:0] m_ready = '0;
    logic [NREQ-1:0] prev_valid = '0, prev_ready = '0;
    bit              proto_en = 1'b0, count_en = 1'b0;
    int              n_grant = 0, n_taken = 0;
    int              g, idx;
    bit              acc, em;
    logic [W-1:0]    ea, eb;
    longint          ua, ub, sa, sb, full, sres;

    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            m_last = NREQ - 1; m_ha = '0; m_hb = '0; m_hm = 1'b0;
            m_ready = '0; prev_valid = '0; prev_ready = '0;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            acc = !m_valid || rsp_ready;
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (g < 0 && ((req_valid >> idx) & 1) != 0) g = idx;
            end
            if (acc && g >= 0) begin
                m_ready = NREQ'(1) << g;
                ea = W'(req_a >> (g*W));
                eb = W'(req_b >> (g*W));
                em = ((req_mode >> g) & 1) != 0;
            end else begin
                m_ready = '0;
                ea = m_ha; eb = m_hb; em = m_hm;
            end
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("add_a", 32'(add_a), 32'(ea));
            chk("add_b", 32'(add_b), 32'(eb));
            chk("add_mode", 32'(add_mode), 32'(em));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
                chk("rsp_cout", 32'(rsp_cout), 32'(m_cout));
                chk("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
            end
            if (proto_en)
                chk("no_withdraw", 32'(prev_valid & ~prev_ready & ~req_valid), 32'd0);
            if (count_en) begin
                if (m_ready != '0) n_grant++;
                if (rsp_valid && rsp_ready) n_taken++;
            end
            prev_valid = req_valid;
            prev_ready = m_ready;
            if (m_ready != '0) begin
                ua = longint'(ea); ub = longint'(eb);
                sa = longint'($signed(ea)); sb = longint'($signed(eb));
                if (!em) begin
                    full = ua + ub;                       sres = sa + sb;
                end else begin
                    full = ua + (longint'(1) << W) - ub;  sres = sa - sb;
                end
                m_sum  = W'(full);
                m_cout = full >= (longint'(1) << W);
                m_ovf  = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
                m_valid = 1'b1; m_id = g; m_last = g;
                m_ha = ea; m_hb = eb; m_hm = em;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        ta[i] = a; tb[i] = b; tm[i] = m; tv[i] = 1'b1;
    endtask

    task automatic single(input string tag, input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input logic [W-1:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        set_req(i, a, b, m);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << i);
        @(posedge clk); #1;
        tv[i] = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(i));
        chk({tag, "_sum"}, 32'(rsp_sum), 32'(es));
        chk({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(eo));
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [NREQ-1:0] keep;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0; tb[i] = '0; tm[i] = 1'b0; tv[i] = 1'b0;
        end
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_id", 32'(rsp_id), 32'd0);
        chk("reset_sum", 32'(rsp_sum), 32'd0);
        chk("reset_cout", 32'(rsp_cout), 32'd0);
        chk("reset_ovf", 32'(rsp_ovf), 32'd0);
        chk("reset_add_a", 32'(add_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request and arithmetic corners
        single("wrap0",  0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("addovf", 2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        single("subovf", 2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single("subneg", 2, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("plain3", 3, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Fairness: everyone valid, ready held high
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, W'(16'h1000 * (i + 1)), W'(i + 1), 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair_grant", 32'(req_ready), 32'(1) << (k % 4));
            if (k > 0) begin
                chk("fair_valid", 32'(rsp_valid), 32'd1);
                chk("fair_id", 32'(rsp_id), 32'((k - 1) % 4));
                chk("fair_sum", 32'(rsp_sum), 32'(16'h1001 * ((k - 1) % 4 + 1)));
            end
        end

        // Backpressure with req1 and req3 pending
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tv[0] = 1'b0; tv[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_sum", 32'(rsp_sum), 32'h4004);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'b0010);
        chk("bp_release_old_id", 32'(rsp_id), 32'd3);
        @(posedge clk); #1;
        tv[1] = 1'b0;
        @(negedge clk);
        chk("bp_new_id", 32'(rsp_id), 32'd1);
        chk("bp_new_sum", 32'(rsp_sum), 32'h2002);
        chk("bp_next_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        tv[3] = 1'b0;
        @(negedge clk);
        chk("bp_last_id", 32'(rsp_id), 32'd3);
        chk("bp_last_sum", 32'(rsp_sum), 32'h4004);

        // Asynchronous reset while FULL with requests pending
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) tv[i] = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) tv[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Random phase
        proto_en = 1'b1;
        count_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            keep = req_valid & ~m_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (((keep >> i) & 1) == 0) begin
                    tv[i] = ($urandom_range(0, 9) < 6);
                    ta[i] = rnd_op();
                    tb[i] = rnd_op();
                    tm[i] = $urandom_range(0, 1) == 1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        proto_en = 1'b0;
        for (int i = 0; i < NREQ; i++) tv[i] = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        count_en = 1'b0;
        chk("rsp_count", 32'(n_taken), 32'(n_grant));
        chk("drained", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
